regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised two-read/two-write integer register file with an integrated busy scoreboard.
- Sits between decode and writeback in the pipelined datapath.
- Holds architectural registers and tracks which are awaiting a writeback from a long-latency unit (load, multiply).
- Reports per-read-port operand readiness to the hazard unit.

Parameters:
DATA_W, 64, data width of each register and bus
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
ZERO_REG, 31, index of hardwired-zero register; reads 0, writes and issues ignored

Ports:
Clk  in  1  clock, all state updates on rising edge
ResetL  in  1  asynchronous active-low reset
RA  in  ADDR_W  read port A index
RB  in  ADDR_W  read port B index
BusA  out  DATA_W  read port A data
BusB  out  DATA_W  read port B data
RdyA  out  1  operand A not busy
RdyB  out  1  operand B not busy
W0En  in  1  write port 0 enable (ALU writeback)
W0Addr  in  ADDR_W  write port 0 index
W0Data  in  DATA_W  write port 0 data
W1En  in  1  write port 1 enable (long-latency writeback)
W1Addr  in  ADDR_W  write port 1 index
W1Data  in  DATA_W  write port 1 data
IssueEn  in  1  mark IssueRd busy (long-latency op issued)
IssueRd  in  ADDR_W  destination of issued op
BusyCount  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (ResetL=0, async): all registers 0, all busy bits 0, BusyCount 0. Outputs settle combinationally: BusA/BusB=0, RdyA/RdyB=1. State held while ResetL low; first update on first rising edge after deassertion.
- Read: combinational, zero-cycle latency.
  - BusX = reg[RX]; RdyX = ~busy[RX].
  - RX == ZERO_REG gives BusX=0 and RdyX=1 always.
- Write, rising edge: WnEn=1 and WnAddr != ZERO_REG writes WnData to reg[WnAddr].
  - Both ports enabled to the same address: W1 wins, W0 dropped.
  - Different addresses: both written.
- Scoreboard, rising edge:
  - IssueEn and IssueRd != ZERO_REG sets busy[IssueRd].
  - Either write port enabled to a non-zero address clears busy[WnAddr].
  - Set and clear of the same index in the same cycle: set wins (new producer supersedes the retiring one); data is still written.
  - Issue to an already-busy register: stays busy, count unchanged.
  - Clear of a non-busy register: no-op, count unchanged.
- BusyCount: registered; equals the population count of the busy bits after each edge.
  - Updated incrementally: +1 for each newly set bit, -1 for each newly cleared bit; max net change per cycle is +1 / -2.
  - Never exceeds DEPTH-1; never underflows.
- Reset asserted mid-operation: pending writes and issues in that cycle are discarded.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If WnEn and WnAddr == RX (non-zero), BusX = WnData (W1 priority over W0) and RdyX = 1, even if busy or if an issue to RX is occurring the same cycle.
- Undefined: reads return pre-edge register contents and readiness; the new value and ready are visible the cycle after the write.

Test Plan:
- Reset then read: ResetL=0, RA=3, RB=31 -> BusA=0, BusB=0, RdyA=RdyB=1, BusyCount=0.
- Write and read back: W0En=1, W0Addr=5, W0Data=64'hDEAD_BEEF_0000_0001 -> next cycle RA=5 gives that value. Write to 31 with 64'hFFFF... -> RB=31 still reads 0.
- Dual-write collision: W0 and W1 both to reg 7 with 64'h11 / 64'h22 -> reg 7 reads 64'h22.
- Scoreboard: IssueEn to 9 -> next cycle RdyA=0 for RA=9, BusyCount=1. Then W1 write to 9 with 64'h42 -> next cycle RdyA=1, BusA=64'h42, BusyCount=0.
- Simultaneous issue and clear:
  - Reg 4 busy; same cycle IssueRd=4 and W1Addr=4 -> reg 4 stays busy, BusyCount unchanged, data written.
  - Issue 10 while W0 clears busy 12 -> BusyCount net 0.
- Bypass: BusA = W0Data with RdyA=1 in the write cycle only when REGFILE_SB_BYPASS_EN is defined; otherwise old value in that cycle.

Source files
------------

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/write/issue bus between the pipeline and regfile_sb
interface regfile_sb_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic              RdyA;
    logic              RdyB;
    logic              W0En;
    logic [ADDR_W-1:0] W0Addr;
    logic [DATA_W-1:0] W0Data;
    logic              W1En;
    logic [ADDR_W-1:0] W1Addr;
    logic [DATA_W-1:0] W1Data;
    logic              IssueEn;
    logic [ADDR_W-1:0] IssueRd;
    logic [ADDR_W:0]   BusyCount;

    modport master (
        output RA, RB, W0En, W0Addr, W0Data, W1En, W1Addr, W1Data, IssueEn, IssueRd,
        input  BusA, BusB, RdyA, RdyB, BusyCount
    );

    modport slave (
        input  RA, RB, W0En, W0Addr, W0Data, W1En, W1Addr, W1Data, IssueEn, IssueRd,
        output BusA, BusB, RdyA, RdyB, BusyCount
    );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R/2W register file with busy scoreboard; optional REGFILE_SB_BYPASS_EN
module regfile_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic         Clk,
    input  logic         ResetL,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic w0_v, w1_v, w0_keep, iss_v;
    logic set_n, clr0_n, clr1_n;

    assign w0_v    = bus.W0En && (bus.W0Addr != ZR);
    assign w1_v    = bus.W1En && (bus.W1Addr != ZR);
    assign w0_keep = w0_v && !(w1_v && (bus.W1Addr == bus.W0Addr));
    assign iss_v   = bus.IssueEn && (bus.IssueRd != ZR);

    // Issue is applied after the clears so a new producer supersedes a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (w0_v) busy_d[bus.W0Addr] = 1'b0;
        if (w1_v) busy_d[bus.W1Addr] = 1'b0;
        if (iss_v) busy_d[bus.IssueRd] = 1'b1;
    end

    // Count only real transitions; w0_keep stops a shared W0/W1 index being cleared twice.
    assign set_n  = iss_v && !busy_q[bus.IssueRd];
    assign clr0_n = w0_keep && busy_q[bus.W0Addr] && !(iss_v && (bus.IssueRd == bus.W0Addr));
    assign clr1_n = w1_v && busy_q[bus.W1Addr] && !(iss_v && (bus.IssueRd == bus.W1Addr));

    always_comb begin
        count_d = count_q + (ADDR_W+1)'(set_n) - (ADDR_W+1)'(clr0_n) - (ADDR_W+1)'(clr1_n);
    end

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (w0_keep) regs_q[bus.W0Addr] <= bus.W0Data;
            if (w1_v)    regs_q[bus.W1Addr] <= bus.W1Data;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign bus.BusyCount = count_q;

    always_comb begin
        bus.BusA = regs_q[bus.RA];
        bus.RdyA = !busy_q[bus.RA];
`ifdef REGFILE_SB_BYPASS_EN
        if (w1_v && (bus.W1Addr == bus.RA)) begin
            bus.BusA = bus.W1Data;
            bus.RdyA = 1'b1;
        end else if (w0_v && (bus.W0Addr == bus.RA)) begin
            bus.BusA = bus.W0Data;
            bus.RdyA = 1'b1;
        end
`endif
        if (bus.RA == ZR) begin
            bus.BusA = '0;
            bus.RdyA = 1'b1;
        end
    end

    always_comb begin
        bus.BusB = regs_q[bus.RB];
        bus.RdyB = !busy_q[bus.RB];
`ifdef REGFILE_SB_BYPASS_EN
        if (w1_v && (bus.W1Addr == bus.RB)) begin
            bus.BusB = bus.W1Data;
            bus.RdyB = 1'b1;
        end else if (w0_v && (bus.W0Addr == bus.RB)) begin
            bus.BusB = bus.W0Data;
            bus.RdyB = 1'b1;
        end
`endif
        if (bus.RB == ZR) begin
            bus.BusB = '0;
            bus.RdyB = 1'b1;
        end
    end
endmodule
